// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 serial receiver. Synchronizes the asynchronous line, finds
//             and validates the start bit, samples each data bit at mid-bit,
//             checks the stop bit and presents the byte on a level-held
//             ready/acknowledge interface with framing and overrun flags.
//  Ports    : clk_50m  - system clock, all state on its rising edge
//             rst_n    - asynchronous active-low reset
//             uart_rxd - serial line, idle high, asynchronous to clk_50m
//             rx_ack   - one-cycle pulse, clears rx_rdy/rx_ferr/rx_ovr
//             rx_data  - last good byte received
//             rx_rdy   - a good byte is waiting in rx_data
//             rx_ferr  - sticky: a frame had a zero stop bit
//             rx_ovr   - sticky: a good byte was dropped while rx_rdy was set
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int RX_CLKS    = 434,
  parameter int RX_DATA_BW = 8
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  uart_rxd,
  input  logic                  rx_ack,
  output logic [RX_DATA_BW-1:0] rx_data,
  output logic                  rx_rdy,
  output logic                  rx_ferr,
  output logic                  rx_ovr
);

  localparam int CW = (RX_CLKS > 1) ? $clog2(RX_CLKS) : 1;
  localparam int IW = (RX_DATA_BW > 1) ? $clog2(RX_DATA_BW) : 1;

  localparam logic [CW-1:0] c_HALF     = CW'(RX_CLKS / 2);
  localparam logic [CW-1:0] c_LAST     = CW'(RX_CLKS - 1);
  localparam logic [IW-1:0] c_IDX_LAST = IW'(RX_DATA_BW - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [RX_DATA_BW-1:0] r_shift;

  logic r_s1;
  logic r_s2;
  logic r_s3;
  // Marks which synchronizer stages hold a genuine line sample since reset.
  // Without it, the high reset values of s1/s2 followed by a line that is
  // already low would look like a falling edge.
  logic [2:0] r_vld;
  logic       w_fall;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_s3  <= 1'b1;
      r_vld <= 3'b000;
    end else begin
      r_s1  <= uart_rxd;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_vld <= {r_vld[1:0], 1'b1};
    end
  end

  assign w_fall = r_vld[2] & r_s3 & ~r_s2;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      rx_ferr <= 1'b0;
      rx_ovr  <= 1'b0;
    end else begin
      // Acknowledge clears first; a same-cycle set from STOP below wins.
      if (rx_ack) begin
        rx_rdy  <= 1'b0;
        rx_ferr <= 1'b0;
        rx_ovr  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_cnt == c_HALF) begin
            if (r_s2) begin
              r_state <= S_IDLE;          // line back high: glitch
            end else begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == c_LAST) begin
            r_shift[r_idx] <= r_s2;
            r_cnt          <= '0;
            if (r_idx == c_IDX_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (r_cnt == c_LAST) begin
            r_cnt <= '0;
            if (r_s2) begin
              if (!rx_rdy || rx_ack) begin
                rx_data <= r_shift;
                rx_rdy  <= 1'b1;
              end else begin
                rx_ovr  <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              rx_ferr <= 1'b1;
              r_state <= S_WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // Hold off until the line recovers so a break flags only once.
        S_WAIT_HI: begin
          if (r_s2) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Frame results are pushed to a
//             scoreboard with the clock edge at which they must be visible.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       uart_rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ferr;
  logic       rx_ovr;

  uart_rx #(.RX_CLKS(434), .RX_DATA_BW(8)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .uart_rxd(uart_rxd),
    .rx_ack  (rx_ack),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_ferr (rx_ferr),
    .rx_ovr  (rx_ovr)
  );

  always #10 clk_50m = ~clk_50m;

  // Edge counter: after rising edge E, cyc == E.
  longint cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  typedef struct {
    longint     due;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of the consumer-visible state
  logic [7:0] m_data;
  logic       m_rdy, m_ferr, m_ovr;

  initial begin : scoreboard
    exp_t e;
    forever begin
      @(posedge clk_50m);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (rx_data !== e.data) begin
          n_bad++;
          $display("FAIL sb_data edge %0d: got %02h expected %02h", e.due, rx_data, e.data);
        end
        n_cmp++;
        if (rx_rdy !== e.rdy) begin
          n_bad++;
          $display("FAIL sb_rdy edge %0d: got %b expected %b", e.due, rx_rdy, e.rdy);
        end
        n_cmp++;
        if (rx_ferr !== e.ferr) begin
          n_bad++;
          $display("FAIL sb_ferr edge %0d: got %b expected %b", e.due, rx_ferr, e.ferr);
        end
        n_cmp++;
        if (rx_ovr !== e.ovr) begin
          n_bad++;
          $display("FAIL sb_ovr edge %0d: got %b expected %b", e.due, rx_ovr, e.ovr);
        end
      end
    end
  end

  // Sends one frame with cpb clocks per bit. The start bit is driven at a
  // falling clock edge, so the next rising edge is T0 and the result must be
  // visible right after edge T0+4126 (receiver timing is independent of cpb).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb,
                            input bit ack_stop, input bit chk_pre, input bit push);
    longint t0;
    exp_t   e;
    @(negedge clk_50m);
    t0 = cyc + 1;
    if (push) begin
      if (chk_pre) begin
        e.due = t0 + 4125; e.data = m_data; e.rdy = m_rdy; e.ferr = m_ferr; e.ovr = m_ovr;
        sb.push_back(e);
      end
      if (ack_stop) begin
        m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      end
      if (stop) begin
        if (!m_rdy) begin
          m_data = d; m_rdy = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        m_ferr = 1'b1;
      end
      e.due = t0 + 4126; e.data = m_data; e.rdy = m_rdy; e.ferr = m_ferr; e.ovr = m_ovr;
      sb.push_back(e);
    end
    fork
      begin
        uart_rxd = 1'b0;
        repeat (cpb) @(negedge clk_50m);
        for (int i = 0; i < 8; i++) begin
          uart_rxd = d[i];
          repeat (cpb) @(negedge clk_50m);
        end
        uart_rxd = stop;
        repeat (cpb) @(negedge clk_50m);
      end
      begin
        if (ack_stop) begin
          while (cyc != t0 + 4125) @(negedge clk_50m);
          rx_ack = 1'b1;
          @(negedge clk_50m);
          rx_ack = 1'b0;
        end
      end
    join
  endtask

  task automatic do_ack();
    @(negedge clk_50m);
    rx_ack = 1'b1;
    @(negedge clk_50m);
    rx_ack = 1'b0;
    m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    uart_rxd = 1'b1;
    rx_ack   = 1'b0;
    rst_n    = 1'b0;
    m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (5) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50m);
    n_cmp++;
    if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h expected 00", rx_data); end
    n_cmp++;
    if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b expected 0", rx_rdy); end
    n_cmp++;
    if (rx_ferr !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", rx_ferr); end
    n_cmp++;
    if (rx_ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b expected 0", rx_ovr); end
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, 1'b1, 434, 1'b0, 1'b1, 1'b1);
    do_ack();
    n_cmp++;
    if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL single_ack_rdy: got %b expected 0", rx_rdy); end
    n_cmp++;
    if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_ack_data: got %02h expected a5", rx_data); end
  endtask

  task automatic test_glitch();
    @(negedge clk_50m);
    uart_rxd = 1'b0;
    repeat (100) @(negedge clk_50m);
    uart_rxd = 1'b1;
    repeat (400) @(negedge clk_50m);
    n_cmp++;
    if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL glitch_rdy: got %b expected 0", rx_rdy); end
    n_cmp++;
    if (rx_ferr !== 1'b0) begin n_bad++; $display("FAIL glitch_ferr: got %b expected 0", rx_ferr); end
    send_frame(8'h3C, 1'b1, 434, 1'b0, 1'b0, 1'b1);
    do_ack();
  endtask

  task automatic test_framing();
    send_frame(8'h55, 1'b0, 434, 1'b0, 1'b0, 1'b1);
    repeat (20 * 434) @(negedge clk_50m);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk_50m);
    n_cmp++;
    if (rx_ferr !== 1'b1) begin n_bad++; $display("FAIL break_ferr: got %b expected 1", rx_ferr); end
    n_cmp++;
    if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL break_rdy: got %b expected 0", rx_rdy); end
    n_cmp++;
    if (rx_data !== m_data) begin n_bad++; $display("FAIL break_data: got %02h expected %02h", rx_data, m_data); end
    send_frame(8'h81, 1'b1, 434, 1'b0, 1'b0, 1'b1);
    do_ack();
    n_cmp++;
    if (rx_ferr !== 1'b0) begin n_bad++; $display("FAIL break_ack_ferr: got %b expected 0", rx_ferr); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 434, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 434, 1'b0, 1'b0, 1'b1);   // dropped: overrun
    send_frame(8'h22, 1'b1, 434, 1'b1, 1'b0, 1'b1);   // ack on stop cycle: accepted
    do_ack();
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(8'h00, 1'b1, 434, 1'b0, 1'b0, 1'b0);
      begin
        repeat (2300) @(negedge clk_50m);   // inside data bit 4, line low
        rst_n = 1'b0;
        repeat (4) @(negedge clk_50m);
        rst_n = 1'b1;
        m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      end
    join
    repeat (10) @(negedge clk_50m);
    n_cmp++;
    if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL midrst_rdy: got %b expected 0", rx_rdy); end
    n_cmp++;
    if (rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %02h expected 00", rx_data); end
    n_cmp++;
    if ({rx_ferr, rx_ovr} !== 2'b00) begin n_bad++; $display("FAIL midrst_flags: got %b%b expected 00", rx_ferr, rx_ovr); end
    send_frame(8'hF0, 1'b1, 434, 1'b0, 1'b0, 1'b1);
    do_ack();
  endtask

  task automatic test_baud_skew();
    int         rates [2];
    logic [7:0] bytes [3];
    rates[0] = 421; rates[1] = 447;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 3; b++) begin
        send_frame(bytes[b], 1'b1, rates[r], 1'b1, 1'b0, 1'b1);
      end
    end
    do_ack();
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_baud_skew();
    repeat (5) @(negedge clk_50m);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Receive half of the board's 8N1 serial link at 115200 baud from the 50 MHz system clock; the partner of the existing transmitter. It synchronizes the asynchronous `uart_rxd` line, detects and validates start bits, samples each data bit at mid-bit and checks the stop bit. Each completed byte is presented on a level-held ready/acknowledge interface with framing-error and overrun flags.

## Interface
- `RX_CLKS`, 434, clocks per bit: 50e6/115200, rounded. Counter width must be sufficient for `RX_CLKS` (9 bits at the default).
- `RX_DATA_BW`, 8, data bits per frame, LSB first.
- `clk_50m`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `uart_rxd`  in  1  serial line, asynchronous to `clk_50m`, idle high.
- `rx_ack`  in  1  consumer acknowledge; one-cycle pulse clears `rx_rdy`, `rx_ferr` and `rx_ovr`.
- `rx_data`  out  RX_DATA_BW  last good byte received.
- `rx_rdy`  out  1  a good byte is waiting in `rx_data`.
- `rx_ferr`  out  1  sticky flag: a frame had stop bit = 0.
- `rx_ovr`  out  1  sticky flag: a good byte was dropped because `rx_rdy` was still set.

## Operation
- **Synchronizer**
  - `uart_rxd` passes through 2 flops (`s1`, `s2`); both reset to 1.
  - `s2` is the sampled line; a third flop `s3` holds the previous `s2`.
  - Falling edge = `s3`=1 and `s2`=0.
- **States:** IDLE, START, DATA, STOP, WAIT_HI. Bit counter `cnt` and bit index `idx`.
- **IDLE:** on a falling edge, clear `cnt` and go to START. A level-low line without an edge is ignored, e.g. after reset while the line is low.
- **START**
  - `cnt` increments each cycle.
  - When `cnt` == `RX_CLKS/2` (integer division, 217), sample `s2`:
    - `s2`=1: glitch; return to IDLE.
    - `s2`=0: clear `cnt`, set `idx`=0 and go to DATA.
- **DATA**
  - When `cnt` == `RX_CLKS-1`, shift `s2` into the shift register at position `idx` (LSB first) and clear `cnt`.
  - After bit `RX_DATA_BW-1`, go to STOP.
- **STOP:** when `cnt` == `RX_CLKS-1`, sample `s2`:
  - `s2`=1 and `rx_rdy`=0, or `rx_ack` this cycle: load `rx_data` from the shift register, set `rx_rdy`, go to IDLE.
  - `s2`=1 and `rx_rdy`=1 with no `rx_ack`: keep `rx_data` unchanged, set `rx_ovr`, go to IDLE.
  - `s2`=0: discard the byte, set `rx_ferr`, go to WAIT_HI.
- **WAIT_HI:** stay until `s2`=1, then go to IDLE. A break condition therefore produces exactly one `rx_ferr`.
- **`rx_ack`**
  - Clears `rx_rdy`, `rx_ferr` and `rx_ovr` on the next edge.
  - The same-cycle set from STOP wins: `rx_rdy`/`rx_ferr` end up 1 with the new byte/event, and no overrun is flagged.
  - `rx_ack` while `rx_rdy`=0 is harmless.
- **Shift register** is not visible; `rx_data` changes only on a good, accepted stop bit.
- **Reset** (any time, including mid-frame): state IDLE, `cnt`=0, `idx`=0, and all outputs as listed under Timing. A partial frame is lost with no flags.

## Timing
- Reset values: `rx_data`=0, `rx_rdy`=0, `rx_ferr`=0, `rx_ovr`=0.
- Let T0 be the `clk_50m` edge at which the `uart_rxd` falling edge is first captured in `s1`. The falling edge is seen (`s2`=0, `s3`=1) at T0+1; START is entered at T0+2.
- Start bit is validated at T0+2+217.
- Data bit k (k=0..7) is sampled at T0+2+217+(k+1)·434.
- Stop bit is sampled at T0+2+217+9·434 = T0+4125. `rx_rdy`/`rx_ferr`/`rx_ovr` are visible from the following cycle.
- Back-to-back frames:
  - The receiver re-arms in IDLE about half a bit before the nominal stop-bit end.
  - The next start edge is accepted with no gap frames lost.
- Tolerates at least ±3 % baud mismatch through mid-bit sampling.

## Test plan
- **Single byte:** reset; send 0xA5 at exactly 434 clk/bit → `rx_rdy` rises at T0+4126 with `rx_data`=0xA5 and both flags 0; `rx_ack` pulse → `rx_rdy`=0 next cycle.
- **Glitch:** line low for 100 cycles, then high → no `rx_rdy`, state back to IDLE at T0+219; a subsequent 0x3C is received correctly.
- **Framing/break:** send 0x55 with stop=0, then hold the line low for 20 bit times → `rx_ferr`=1 once, `rx_rdy`=0, `rx_data` unchanged; after the line returns high, 0x81 is received with `rx_ferr` still 1 until `rx_ack`.
- **Overrun:** send 0x11 and 0x22 back-to-back with no ack → `rx_data`=0x11, `rx_rdy`=1, `rx_ovr`=1. With `rx_ack` asserted on the stop-sample cycle of 0x22 → `rx_data`=0x22, `rx_rdy`=1, `rx_ovr`=0.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4, release while the line is low → no byte and no flags; the next full frame 0xF0 is received correctly.
- **Baud skew:** stream 0x00, 0xFF, 0x5A at 421 and at 447 clk/bit (±3 %) → all three bytes correct, no flags.
